// File: rtl/datapath_param.sv
`default_nettype none
// ============================================================================
// datapath_param
// Parametrised RISC datapath: register file, A/B/C operands, shifter, ALU,
// status register and an iterative shift-add multiplier (start/busy/done).
// Revision: 1.0
// ============================================================================
module datapath_param #(
  parameter int W     = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [$clog2(NREGS)-1:0] writenum,
  input  logic [$clog2(NREGS)-1:0] readnum,
  input  logic [1:0]               vsel,
  input  logic                     loada,
  input  logic                     loadb,
  input  logic                     loadc,
  input  logic                     loads,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic [1:0]               shift,
  input  logic [2:0]               aluop,
  input  logic                     start,
  input  logic [W-1:0]             mdata,
  input  logic [W-1:0]             sximm8,
  input  logic [W-1:0]             sximm5,
  input  logic [PCW-1:0]           pc,
  output logic [W-1:0]             datapath_out,
  output logic [2:0]               flags,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(W);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    regs [NREGS];
  logic [W-1:0]    a_q, b_q, c_q;
  logic [2:0]      flags_q;
  logic            done_q;
  logic [2*W-1:0]  mcand_q, acc_q, acc_next;
  logic [W-1:0]    mplier_q;
  logic [CW-1:0]   cnt_q;

  logic [W-1:0]    read_data, write_data, pc_ext;
  logic [W-1:0]    b_shift, ain, bin, alu_res, mul_res;
  logic            alu_v;
  logic [2:0]      alu_flags, mul_flags;
  logic            mul_accept, mul_last;

  assign busy         = (state_q == ST_MUL);
  assign done         = done_q;
  assign datapath_out = c_q;
  assign flags        = flags_q;

  assign read_data = regs[readnum];
  assign pc_ext    = W'(pc);

  always_comb begin
    write_data = c_q;
    case (vsel)
      2'b01:   write_data = pc_ext;
      2'b10:   write_data = mdata;
      2'b11:   write_data = sximm8;
      default: write_data = c_q;
    endcase
  end

  always_comb begin
    b_shift = b_q;
    case (shift)
      2'b01:   b_shift = {b_q[W-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[W-1:1]};
      2'b11:   b_shift = {b_q[W-1], b_q[W-1:1]};
      default: b_shift = b_q;
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : b_shift;

  // MUL without an accepted start, and the reserved codes, behave as ADD
  always_comb begin
    alu_res = ain + bin;
    alu_v   = (ain[W-1] == bin[W-1]) && (alu_res[W-1] != ain[W-1]);
    case (aluop)
      3'b001: begin
        alu_res = ain - bin;
        alu_v   = (ain[W-1] != bin[W-1]) && (alu_res[W-1] != ain[W-1]);
      end
      3'b010: begin
        alu_res = ain & bin;
        alu_v   = 1'b0;
      end
      3'b011: begin
        alu_res = ~bin;
        alu_v   = 1'b0;
      end
      default: begin
        alu_res = ain + bin;
        alu_v   = (ain[W-1] == bin[W-1]) && (alu_res[W-1] != ain[W-1]);
      end
    endcase
  end

  assign alu_flags = {alu_v, alu_res[W-1], (alu_res == '0)};

  // Final iteration folds into the completion edge, so the result is taken
  // from the next-accumulator value rather than the registered one.
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res   = acc_next[W-1:0];
  assign mul_flags = {(|acc_next[2*W-1:W]), mul_res[W-1], (mul_res == '0)};

  assign mul_accept = start && (aluop == 3'b100) && (state_q == ST_IDLE);
  assign mul_last   = (state_q == ST_MUL) && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_accept) state_d = ST_MUL;
      ST_MUL:  if (mul_last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write) begin
      regs[writenum] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= mul_last;
      if (!busy) begin
        if (loada) a_q     <= read_data;
        if (loadb) b_q     <= read_data;
        if (loadc) c_q     <= alu_res;
        if (loads) flags_q <= alu_flags;
      end else if (mul_last) begin
        c_q     <= mul_res;
        flags_q <= mul_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (mul_accept) begin
      mcand_q  <= {{W{1'b0}}, ain};
      mplier_q <= bin;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (busy) begin
      mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
      acc_q    <= acc_next;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule
`default_nettype wire
